// File: rtl/bp_be_pkg.sv
// Shared types for the backend scoreboard hazard detector: the scoreboard entry
// layout, the remaining-latency width and the register-file select used by match logic.
package bp_be_pkg;

  localparam int max_pipe_depth_gp = 15;
  localparam int rem_width_gp      = $clog2(max_pipe_depth_gp + 1);

  typedef enum logic {
    rf_int_e = 1'b0,
    rf_fp_e  = 1'b1
  } rf_sel_e;

  typedef struct packed {
    logic                    v;
    logic [4:0]              rd;
    logic                    irf;
    logic                    frf;
    logic [rem_width_gp-1:0] rem;
  } sb_entry_s;

  // A consumer dispatched now reaches EX one cycle later, when the producer's rem has
  // dropped by one; rem<=2 here therefore means the result is bypassable by then.
  function automatic logic entry_hit(input sb_entry_s e, input logic [4:0] addr,
                                     input rf_sel_e sel);
    logic file_hit;
    file_hit = (sel == rf_int_e) ? (e.irf && (addr != 5'd0)) : e.frf;
    return e.v && file_hit && (e.rd == addr) && (e.rem > rem_width_gp'(2));
  endfunction

endpackage

// File: rtl/bp_be_detector_sb_entry.sv
// One scoreboard stage: holds an in-flight write and flags a RAW conflict against
// the sources of the instruction currently in ISD.
module bp_be_detector_sb_entry
  import bp_be_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  sb_entry_s  entry_n_i,
  output sb_entry_s  entry_o,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       irs1_v_i,
  input  logic       irs2_v_i,
  input  logic       frs1_v_i,
  input  logic       frs2_v_i,
  output logic       haz_o
);

  // NOTE: the whole stage is cleared on reset, not just the valid bit, so a stale rd
  // or rem can never be observed; sequential state uses non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (reset_i) entry_o <= '0;
    else         entry_o <= entry_n_i;
  end

  assign haz_o = (irs1_v_i && entry_hit(entry_o, rs1_i, rf_int_e))
               | (irs2_v_i && entry_hit(entry_o, rs2_i, rf_int_e))
               | (frs1_v_i && entry_hit(entry_o, rs1_i, rf_fp_e))
               | (frs2_v_i && entry_hit(entry_o, rs2_i, rf_fp_e));

endmodule

// File: rtl/bp_be_detector_sb.sv
// Scoreboard hazard detector: decides ISD dispatch, ISD/EX poison, tracks in-flight
// writes with per-op latency, long-latency credits and a saturating stall counter.
module bp_be_detector_sb
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p     = 56,
  parameter int pipe_depth_p      = 5,
  parameter int commit_stage_p    = 3,
  parameter int num_fu_p          = 4,
  parameter int long_credits_p    = 2,
  parameter int stall_cnt_width_p = 16,
  parameter int lat_width_p       = $clog2(pipe_depth_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         issue_v_i,
  input  logic [4:0]                   issue_rs1_i,
  input  logic [4:0]                   issue_rs2_i,
  input  logic                         issue_irs1_v_i,
  input  logic                         issue_irs2_v_i,
  input  logic                         issue_frs1_v_i,
  input  logic                         issue_frs2_v_i,
  input  logic [4:0]                   issue_rd_i,
  input  logic                         issue_irf_w_i,
  input  logic                         issue_frf_w_i,
  input  logic [lat_width_p-1:0]       issue_lat_i,
  input  logic [num_fu_p-1:0]          issue_fu_i,
  input  logic                         issue_long_i,
  input  logic [num_fu_p-1:0]          fu_ready_i,
  input  logic                         long_done_i,
  input  logic                         br_v_i,
  input  logic [vaddr_width_p-1:0]     br_npc_i,
  input  logic [vaddr_width_p-1:0]     expected_npc_i,
  input  logic                         roll_i,
  input  logic                         exc_i,
  output logic                         chk_dispatch_v_o,
  output logic                         chk_roll_o,
  output logic                         chk_poison_isd_o,
  output logic                         chk_poison_ex_o,
  output logic [stall_cnt_width_p-1:0] stall_cnt_o
);

  localparam int credit_width_lp = $clog2(long_credits_p + 1);
  localparam logic [credit_width_lp-1:0] credits_full_lp = credit_width_lp'(long_credits_p);

  sb_entry_s                    entry_q [pipe_depth_p];
  sb_entry_s                    entry_n [pipe_depth_p];
  logic [pipe_depth_p-1:0]      entry_haz;
  logic                         data_haz, struct_haz, mispredict, accept, long_accept;
  logic [credit_width_lp-1:0]   credits_r;
  logic [stall_cnt_width_p-1:0] stall_cnt_r;

  assign mispredict       = br_v_i & (br_npc_i != expected_npc_i);
  assign chk_poison_ex_o  = reset_i | roll_i | exc_i;
  assign chk_poison_isd_o = chk_poison_ex_o | mispredict;
  assign chk_roll_o       = roll_i;

  assign data_haz         = |entry_haz;
  assign struct_haz       = (|(issue_fu_i & ~fu_ready_i)) | (issue_long_i & (credits_r == '0));
  assign chk_dispatch_v_o = ~reset_i & ~data_haz & ~struct_haz;
  assign accept           = issue_v_i & chk_dispatch_v_o & ~chk_poison_isd_o;
  assign long_accept      = accept & issue_long_i;
  assign stall_cnt_o      = stall_cnt_r;

  // NOTE: combinational next-state uses blocking assignments and defaults every
  // element first, so no path can leave a latch behind.
  always_comb begin
    entry_n[0] = '0;
    if (accept) begin
      entry_n[0].v   = 1'b1;
      entry_n[0].rd  = issue_rd_i;
      entry_n[0].irf = issue_irf_w_i;
      entry_n[0].frf = issue_frf_w_i;
      entry_n[0].rem = rem_width_gp'(issue_lat_i);
    end
    // Younger stages die on an EX flush; stages at or past commit keep retiring.
    for (int k = 1; k < pipe_depth_p; k++) begin
      entry_n[k]     = entry_q[k-1];
      entry_n[k].rem = entry_q[k-1].rem - rem_width_gp'(1);
      entry_n[k].v   = entry_q[k-1].v && (entry_n[k].rem != '0)
                     && !(chk_poison_ex_o && (k < commit_stage_p));
    end
  end

  for (genvar k = 0; k < pipe_depth_p; k++) begin : g_entry
    bp_be_detector_sb_entry u_entry (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .entry_n_i (entry_n[k]),
      .entry_o   (entry_q[k]),
      .rs1_i     (issue_rs1_i),
      .rs2_i     (issue_rs2_i),
      .irs1_v_i  (issue_irs1_v_i),
      .irs2_v_i  (issue_irs2_v_i),
      .frs1_v_i  (issue_frs1_v_i),
      .frs2_v_i  (issue_frs2_v_i),
      .haz_o     (entry_haz[k])
    );
  end

  // Credits are never flushed: the FU still reports done for ops killed in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_r   <= credits_full_lp;
      stall_cnt_r <= '0;
    end else begin
      if (long_accept && !long_done_i)
        credits_r <= credits_r - credit_width_lp'(1);
      else if (long_done_i && !long_accept && (credits_r != credits_full_lp))
        credits_r <= credits_r + credit_width_lp'(1);

      if (issue_v_i && !chk_dispatch_v_o && (stall_cnt_r != '1))
        stall_cnt_r <= stall_cnt_r + stall_cnt_width_p'(1);
    end
  end

endmodule

// File: tb/tb_bp_be_detector_sb.sv
// Directed self-checking bench for bp_be_detector_sb: RAW stalls, x0/f0 handling,
// poison behaviour, long-op credits, FU readiness, EX flush and stall saturation.
module tb_bp_be_detector_sb;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        issue_v_i;
  logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic        issue_irs1_v_i, issue_irs2_v_i, issue_frs1_v_i, issue_frs2_v_i;
  logic        issue_irf_w_i, issue_frf_w_i;
  logic [2:0]  issue_lat_i;
  logic [3:0]  issue_fu_i, fu_ready_i;
  logic        issue_long_i, long_done_i;
  logic        br_v_i;
  logic [55:0] br_npc_i, expected_npc_i;
  logic        roll_i, exc_i;
  logic        chk_dispatch_v_o, chk_roll_o, chk_poison_isd_o, chk_poison_ex_o;
  logic [15:0] stall_cnt_o;

  int checks    = 0;
  int failures  = 0;
  int exp_stall = 0;

  always #5 clk_i = ~clk_i;

  bp_be_detector_sb dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .issue_v_i        (issue_v_i),
    .issue_rs1_i      (issue_rs1_i),
    .issue_rs2_i      (issue_rs2_i),
    .issue_irs1_v_i   (issue_irs1_v_i),
    .issue_irs2_v_i   (issue_irs2_v_i),
    .issue_frs1_v_i   (issue_frs1_v_i),
    .issue_frs2_v_i   (issue_frs2_v_i),
    .issue_rd_i       (issue_rd_i),
    .issue_irf_w_i    (issue_irf_w_i),
    .issue_frf_w_i    (issue_frf_w_i),
    .issue_lat_i      (issue_lat_i),
    .issue_fu_i       (issue_fu_i),
    .issue_long_i     (issue_long_i),
    .fu_ready_i       (fu_ready_i),
    .long_done_i      (long_done_i),
    .br_v_i           (br_v_i),
    .br_npc_i         (br_npc_i),
    .expected_npc_i   (expected_npc_i),
    .roll_i           (roll_i),
    .exc_i            (exc_i),
    .chk_dispatch_v_o (chk_dispatch_v_o),
    .chk_roll_o       (chk_roll_o),
    .chk_poison_isd_o (chk_poison_isd_o),
    .chk_poison_ex_o  (chk_poison_ex_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_v_i = 0; issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0;
    issue_irs1_v_i = 0; issue_irs2_v_i = 0; issue_frs1_v_i = 0; issue_frs2_v_i = 0;
    issue_irf_w_i = 0; issue_frf_w_i = 0; issue_lat_i = 3'd1;
    issue_fu_i = 4'b0001; fu_ready_i = 4'b1111; issue_long_i = 0; long_done_i = 0;
    br_v_i = 0; br_npc_i = '0; expected_npc_i = '0; roll_i = 0; exc_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Check the combinational outputs for the current inputs, then clock one edge and
  // check the stall counter against the bench's own running count.
  task automatic step(input string tag, input logic d, input logic pi, input logic pe);
    #1;
    check({tag, ".disp"},   32'(chk_dispatch_v_o), 32'(d));
    check({tag, ".p_isd"},  32'(chk_poison_isd_o), 32'(pi));
    check({tag, ".p_ex"},   32'(chk_poison_ex_o),  32'(pe));
    if (issue_v_i && !d && exp_stall < 65535) exp_stall++;
    tick();
    check({tag, ".stall"},  32'(stall_cnt_o), 32'(exp_stall));
  endtask

  initial begin
    idle();
    reset_i = 1;
    tick();
    for (int i = 0; i < 3; i++) step("reset", 0, 1, 1);
    reset_i = 0;

    // Integer RAW on x5, producer latency 3: one stall cycle.
    issue_v_i = 1; issue_rd_i = 5; issue_irf_w_i = 1; issue_lat_i = 3;
    step("int_prod", 1, 0, 0);
    idle(); issue_v_i = 1; issue_rs1_i = 5; issue_irs1_v_i = 1;
    step("int_raw_c1", 0, 0, 0);
    step("int_raw_c2", 1, 0, 0);

    // x0 destination never creates a hazard.
    idle(); issue_v_i = 1; issue_rd_i = 0; issue_irf_w_i = 1; issue_lat_i = 3;
    step("x0_prod", 1, 0, 0);
    idle(); issue_v_i = 1; issue_rs1_i = 0; issue_irs1_v_i = 1;
    step("x0_cons", 1, 0, 0);

    // FP producer f0, latency 4: two stall cycles; int x0 read is unaffected.
    idle(); issue_v_i = 1; issue_rd_i = 0; issue_frf_w_i = 1; issue_lat_i = 4;
    step("fp_prod", 1, 0, 0);
    idle(); issue_v_i = 1; issue_rs1_i = 0; issue_irs1_v_i = 1;
    #1 check("x0_vs_fp.disp", 32'(chk_dispatch_v_o), 32'd1);
    issue_irs1_v_i = 0; issue_frs1_v_i = 1;
    step("fp_c1", 0, 0, 0);
    step("fp_c2", 0, 0, 0);
    step("fp_c3", 1, 0, 0);

    // Mispredict poisons ISD only; the scoreboard keeps the rs2 hazard.
    idle(); issue_v_i = 1; issue_rd_i = 3; issue_irf_w_i = 1; issue_lat_i = 4;
    step("br_prod", 1, 0, 0);
    idle(); issue_v_i = 1; issue_rs2_i = 3; issue_irs2_v_i = 1;
    br_v_i = 1; br_npc_i = 56'h1000; expected_npc_i = 56'h1004;
    step("br_mis", 0, 1, 0);
    br_v_i = 0;
    step("br_keep", 0, 0, 0);
    br_v_i = 1; br_npc_i = 56'h1004;
    step("br_ok", 1, 0, 0);

    // Rollback wins over accept: no entry is allocated.
    idle(); issue_v_i = 1; issue_rd_i = 11; issue_irf_w_i = 1; issue_lat_i = 4; roll_i = 1;
    #1 check("roll_echo1", 32'(chk_roll_o), 32'd1);
    step("roll_prod", 1, 1, 1);
    idle(); issue_v_i = 1; issue_rs1_i = 11; issue_irs1_v_i = 1;
    #1 check("roll_echo0", 32'(chk_roll_o), 32'd0);
    step("roll_cons", 1, 0, 0);

    // Long-latency credits: overflow ignored, stall at zero, accept+done holds.
    idle(); long_done_i = 1;
    step("done_full", 1, 0, 0);
    idle(); issue_v_i = 1; issue_long_i = 1; issue_fu_i = 4'b0010;
    step("long_a", 1, 0, 0);
    step("long_b", 1, 0, 0);
    step("long_c_stall", 0, 0, 0);
    long_done_i = 1;
    step("long_c_done", 0, 0, 0);
    step("long_c_acc", 1, 0, 0);
    long_done_i = 0;
    step("long_d", 1, 0, 0);
    step("long_e_stall", 0, 0, 0);
    idle(); long_done_i = 1; exc_i = 1;
    step("done_flush", 1, 1, 1);
    idle(); issue_v_i = 1; issue_long_i = 1; issue_fu_i = 4'b0010;
    step("long_f", 1, 0, 0);
    step("long_g_stall", 0, 0, 0);

    // Per-channel FU readiness.
    idle(); issue_v_i = 1; issue_fu_i = 4'b0100; fu_ready_i = 4'b1011;
    step("fu_busy", 0, 0, 0);
    fu_ready_i = 4'b0100;
    step("fu_ready", 1, 0, 0);

    // Exception with entries at stages 1 and 4: the young one is flushed.
    idle(); issue_v_i = 1; issue_rd_i = 7; issue_irf_w_i = 1; issue_lat_i = 5;
    step("exc_a", 1, 0, 0);
    idle();
    step("exc_gap1", 1, 0, 0);
    step("exc_gap2", 1, 0, 0);
    issue_v_i = 1; issue_rd_i = 9; issue_irf_w_i = 1; issue_lat_i = 5;
    step("exc_b", 1, 0, 0);
    idle();
    step("exc_gap3", 1, 0, 0);
    issue_v_i = 1; issue_rs1_i = 7; issue_irs1_v_i = 1; exc_i = 1;
    #1 check("exc_old.disp", 32'(chk_dispatch_v_o), 32'd1);
    issue_rs1_i = 9;
    step("exc_flush", 0, 1, 1);
    exc_i = 0;
    step("exc_after", 1, 0, 0);

    // Stall counter saturation under 70000 structural stall cycles.
    idle(); issue_v_i = 1; fu_ready_i = 4'b0000;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (exp_stall < 65535) exp_stall++;
      if (exp_stall == 65534) check("stall_near_sat", 32'(stall_cnt_o), 32'(exp_stall));
    end
    check("stall_sat", 32'(stall_cnt_o), 32'h0000_ffff);

    idle(); reset_i = 1;
    tick();
    reset_i = 0;
    #1 check("stall_reset", 32'(stall_cnt_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
